// File: rtl/dmem_bridge_if.sv
`default_nettype none
// ============================================================================
// Module   : dmem_bridge_if
// Brief    : Request/acknowledge data-memory bus between bridge and memory.
// Revision : 1.0
// ============================================================================
interface dmem_bridge_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_wdata,
        input  bus_ack, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_wdata,
        output bus_ack, bus_rdata
    );
endinterface
`default_nettype wire

// File: rtl/dmem_bridge.sv
`default_nettype none
// ============================================================================
// Module   : dmem_bridge
// Brief    : MEM-stage strobes to req/ack data bus with stall and error checks.
//            Optional bus timeout enabled by defining DMEM_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
module dmem_bridge #(
    parameter logic [31:0] DMEM_BASE      = 32'h1001_0000,
    parameter logic [31:0] DMEM_SIZE      = 32'h0000_1000,
    parameter int          TIMEOUT_CYCLES = 64
) (
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        MemRead,
    input  wire logic        MemWrite,
    input  wire logic [31:0] dAddress,
    input  wire logic [31:0] dWriteData,
    output logic      [31:0] dReadData,
    output logic             stall,
    output logic             err,
    output logic             err_sticky,
    dmem_bridge_if.master    bus
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [1:0] S_ERR  = 2'd3;

    // 33-bit window bounds so BASE+SIZE cannot wrap past 2^32.
    localparam logic [32:0] WIN_LO = {1'b0, DMEM_BASE};
    localparam logic [32:0] WIN_HI = {1'b0, DMEM_BASE} + {1'b0, DMEM_SIZE};

    logic [1:0]  state;
    logic [1:0]  next_state;
    logic [32:0] addr_ext;
    logic        any_strobe;
    logic        in_range;
    logic        legal;
    logic        timeout_hit;

    assign addr_ext   = {1'b0, dAddress};
    assign any_strobe = MemRead | MemWrite;
    assign in_range   = (addr_ext >= WIN_LO) && (addr_ext < WIN_HI);
    assign legal      = (MemRead ^ MemWrite) && (dAddress[1:0] == 2'b00) && in_range;

`ifdef DMEM_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] to_cnt;

    // Counts REQ cycles without an ack; the limit cycle itself still honours ack.
    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt <= 8'd0;
        end else if (state == S_IDLE && legal) begin
            to_cnt <= 8'd0;
        end else if (state == S_REQ && !bus.bus_ack) begin
            to_cnt <= to_cnt + 8'd1;
        end
    end

    assign timeout_hit = (to_cnt == TO_LAST);
`else
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_timeout_range_unused
    end

    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = S_IDLE;
        case (state)
            S_IDLE: begin
                if (legal) begin
                    next_state = S_REQ;
                end else if (any_strobe) begin
                    next_state = S_ERR;
                end
            end
            S_REQ: begin
                if (bus.bus_ack) begin
                    next_state = S_DONE;
                end else if (timeout_hit) begin
                    next_state = S_ERR;
                end else begin
                    next_state = S_REQ;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_comb begin
        bus.bus_req = (state == S_REQ);
        stall       = (state == S_REQ) || (state == S_IDLE && legal);
    end

    // err and err_sticky are registered on entry to ERR so both show in that cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            dReadData     <= 32'd0;
            bus.bus_we    <= 1'b0;
            bus.bus_addr  <= 32'd0;
            bus.bus_wdata <= 32'd0;
            err           <= 1'b0;
            err_sticky    <= 1'b0;
        end else begin
            if (state == S_IDLE && legal) begin
                bus.bus_we    <= MemWrite;
                bus.bus_addr  <= dAddress;
                bus.bus_wdata <= dWriteData;
            end
            if (state == S_REQ && bus.bus_ack && !bus.bus_we) begin
                dReadData <= bus.bus_rdata;
            end
            err        <= (next_state == S_ERR);
            err_sticky <= err_sticky | (next_state == S_ERR);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_bridge
// Brief    : Self-checking bench: vector table, corner sequences, random model.
// Revision : 1.0
// ============================================================================
module tb_dmem_bridge;

    localparam longint BASE  = 64'h1001_0000;
    localparam longint SIZE  = 64'h0000_1000;
    localparam int     TO    = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        MemRead = 1'b0;
    logic        MemWrite = 1'b0;
    logic [31:0] dAddress = 32'd0;
    logic [31:0] dWriteData = 32'd0;
    logic [31:0] dReadData;
    logic        stall;
    logic        err;
    logic        err_sticky;

    dmem_bridge_if bus_if ();

    dmem_bridge #(
        .DMEM_BASE      (32'h1001_0000),
        .DMEM_SIZE      (32'h0000_1000),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .dAddress   (dAddress),
        .dWriteData (dWriteData),
        .dReadData  (dReadData),
        .stall      (stall),
        .err        (err),
        .err_sticky (err_sticky),
        .bus        (bus_if.master)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference state: last completed load data and sticky error flag.
    logic [31:0] m_rd     = 32'd0;
    logic        m_sticky = 1'b0;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          lat;
        int          exp_stall;
        int          exp_req;
        int          exp_err;
        logic [31:0] exp_rd;
        logic        exp_sticky;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic bit legal_m(input logic rd, input logic wr, input logic [31:0] a);
        longint ua;
        ua = a;
        return (rd != wr) && (ua % 4 == 0) && (ua >= BASE) && (ua < BASE + SIZE);
    endfunction

    // One MEM-phase access with a memory answering in the lat-th REQ cycle (0 = never).
    task automatic access(input string nm, input logic rd, input logic wr,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] rdata, input int lat,
                          input int exp_stall, input int exp_req, input int exp_err,
                          input logic [31:0] exp_rd, input logic exp_sticky);
        int ns = 0, nr = 0, ne = 0, hold_bad = 0, cyc = 0;
        bit stop = 0;
        logic [31:0] rdv = 32'd0;
        logic        stk = 1'b0;
        @(posedge clk); #1;
        MemRead = rd; MemWrite = wr; dAddress = a; dWriteData = wd;
        while (!stop && cyc < 40) begin
            @(negedge clk);
            if (stall) ns++;
            if (err) ne++;
            if (bus_if.bus_req) begin
                nr++;
                if (bus_if.bus_addr !== a || bus_if.bus_we !== wr) hold_bad++;
                if (wr && bus_if.bus_wdata !== wd) hold_bad++;
                if (nr == lat) begin
                    bus_if.bus_ack   = 1'b1;
                    bus_if.bus_rdata = rdata;
                end
            end
            if (cyc > 0 && !stall) begin
                stop = 1;
                rdv  = dReadData;
                stk  = err_sticky;
            end
            @(posedge clk); #1;
            bus_if.bus_ack = 1'b0;
            cyc++;
        end
        MemRead = 1'b0; MemWrite = 1'b0;
        if (!stop) chk({nm, "_bound"}, 64'd0, 64'd1);
        @(negedge clk);
        if (err) ne++;
        chk({nm, "_stall"},  64'(ns), 64'(exp_stall));
        chk({nm, "_req"},    64'(nr), 64'(exp_req));
        chk({nm, "_err"},    64'(ne), 64'(exp_err));
        chk({nm, "_rdata"},  64'(rdv), 64'(exp_rd));
        chk({nm, "_sticky"}, 64'(stk), 64'(exp_sticky));
        chk({nm, "_hold"},   64'(hold_bad), 64'd0);
    endtask

    vec_t vecs [9];
    int   exp_req_h   [6] = '{0, 1, 0, 0, 1, 0};
    int   exp_stall_h [6] = '{1, 1, 0, 1, 1, 0};

    initial begin
        bus_if.bus_ack   = 1'b0;
        bus_if.bus_rdata = 32'd0;

        vecs[0] = '{1, 0, 32'h1001_0004, 32'h0,         32'hDEAD_BEEF, 1, 2, 1, 0, 32'hDEAD_BEEF, 0};
        vecs[1] = '{0, 1, 32'h1001_0FFC, 32'h0000_A5A5, 32'h1111_1111, 3, 4, 3, 0, 32'hDEAD_BEEF, 0};
        vecs[2] = '{1, 0, 32'h1001_0000, 32'h0,         32'h1234_5678, 2, 3, 2, 0, 32'h1234_5678, 0};
        vecs[3] = '{1, 0, 32'h1001_0002, 32'h0,         32'h0,         1, 0, 0, 1, 32'h1234_5678, 1};
        vecs[4] = '{1, 0, 32'h1001_1000, 32'h0,         32'h0,         1, 0, 0, 1, 32'h1234_5678, 1};
        vecs[5] = '{1, 1, 32'h1001_0008, 32'h5,         32'h0,         1, 0, 0, 1, 32'h1234_5678, 1};
        vecs[6] = '{0, 1, 32'h1000_FFFC, 32'h6,         32'h0,         1, 0, 0, 1, 32'h1234_5678, 1};
        vecs[7] = '{1, 0, 32'h1001_0FFC, 32'h0,         32'hCAFE_F00D, 1, 2, 1, 0, 32'hCAFE_F00D, 1};
        vecs[8] = '{0, 1, 32'h1001_0FFF, 32'h7,         32'h0,         1, 0, 0, 1, 32'hCAFE_F00D, 1};

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_rdata",  64'(dReadData), 64'd0);
        chk("rst_stall",  64'(stall), 64'd0);
        chk("rst_err",    64'(err), 64'd0);
        chk("rst_sticky", 64'(err_sticky), 64'd0);
        chk("rst_req",    64'(bus_if.bus_req), 64'd0);
        chk("rst_we",     64'(bus_if.bus_we), 64'd0);
        chk("rst_addr",   64'(bus_if.bus_addr), 64'd0);
        chk("rst_wdata",  64'(bus_if.bus_wdata), 64'd0);

        for (int i = 0; i < 9; i++) begin
            access($sformatf("vec%0d", i), vecs[i].rd, vecs[i].wr, vecs[i].addr,
                   vecs[i].wdata, vecs[i].rdata, vecs[i].lat, vecs[i].exp_stall,
                   vecs[i].exp_req, vecs[i].exp_err, vecs[i].exp_rd, vecs[i].exp_sticky);
        end

        // Load strobe held through DONE and one IDLE cycle starts a second transaction.
        @(posedge clk); #1;
        MemRead = 1'b1; dAddress = 32'h1001_0010;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk($sformatf("held_stall%0d", c), 64'(stall), 64'(exp_stall_h[c]));
            chk($sformatf("held_req%0d", c), 64'(bus_if.bus_req), 64'(exp_req_h[c]));
            if (c == 2) chk("held_rdata_first", 64'(dReadData), 64'h0000_0000_0A0A_0A0A);
            if (c == 1 || c == 4) begin
                bus_if.bus_ack   = 1'b1;
                bus_if.bus_rdata = (c == 1) ? 32'h0A0A_0A0A : 32'h0B0B_0B0B;
            end
            @(posedge clk); #1;
            bus_if.bus_ack = 1'b0;
            if (c == 3) MemRead = 1'b0;
        end
        @(negedge clk);
        chk("held_rdata_second", 64'(dReadData), 64'h0000_0000_0B0B_0B0B);

        // Reset while in REQ, followed by a stale ack two cycles later.
        @(posedge clk); #1;
        MemRead = 1'b1; dAddress = 32'h1001_0020;
        @(negedge clk);
        chk("mrst_stall_idle", 64'(stall), 64'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("mrst_req_before", 64'(bus_if.bus_req), 64'd1);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0; MemRead = 1'b0;
        @(negedge clk);
        chk("mrst_req_after", 64'(bus_if.bus_req), 64'd0);
        chk("mrst_rdata",     64'(dReadData), 64'd0);
        chk("mrst_sticky",    64'(err_sticky), 64'd0);
        chk("mrst_err",       64'(err), 64'd0);
        chk("mrst_stall",     64'(stall), 64'd0);
        chk("mrst_addr",      64'(bus_if.bus_addr), 64'd0);
        chk("mrst_we",        64'(bus_if.bus_we), 64'd0);
        chk("mrst_wdata",     64'(bus_if.bus_wdata), 64'd0);
        bus_if.bus_ack   = 1'b1;
        bus_if.bus_rdata = 32'hFFFF_FFFF;
        @(posedge clk); #1 bus_if.bus_ack = 1'b0;
        @(negedge clk);
        chk("late_ack_rdata", 64'(dReadData), 64'd0);
        chk("late_ack_req",   64'(bus_if.bus_req), 64'd0);
        chk("late_ack_stall", 64'(stall), 64'd0);
        chk("late_ack_err",   64'(err), 64'd0);
        m_rd     = 32'd0;
        m_sticky = 1'b0;

`ifdef DMEM_TIMEOUT_EN
        access("ack_at_limit", 1'b1, 1'b0, 32'h1001_0030, 32'h0, 32'h7777_0000, TO,
               1 + TO, TO, 0, 32'h7777_0000, 1'b0);
        m_rd = 32'h7777_0000;
        access("timeout", 1'b1, 1'b0, 32'h1001_0040, 32'h0, 32'h9999_9999, 0,
               1 + TO, TO, 1, m_rd, 1'b1);
        m_sticky = 1'b1;
`endif

        for (int n = 0; n < 150; n++) begin
            logic        rd, wr, lg;
            logic [31:0] a, wd, rdat;
            int          sel, lat;
            sel = $urandom_range(0, 9);
            rd  = (sel == 0) || (sel <= 5);
            wr  = (sel == 0) || (sel > 5);
            case ($urandom_range(0, 5))
                0, 1, 2: a = 32'(BASE + 4 * $urandom_range(0, 1023));
                3:       a = 32'(BASE + 4 * $urandom_range(0, 1023) + $urandom_range(1, 3));
                4:       a = 32'(BASE + SIZE + 4 * $urandom_range(0, 15));
                default: a = 32'(BASE - 4 - 4 * $urandom_range(0, 15));
            endcase
            wd   = $urandom;
            rdat = $urandom;
            lat  = $urandom_range(1, TO);
            lg   = legal_m(rd, wr, a);
            if (lg && rd) m_rd = rdat;
            if (!lg) m_sticky = 1'b1;
            access($sformatf("rnd%0d", n), rd, wr, a, wd, rdat, lat,
                   lg ? 1 + lat : 0, lg ? lat : 0, lg ? 0 : 1, m_rd, m_sticky);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dmem_bridge.md
Name: dmem_bridge

Overview:
- Sits directly downstream of the multicycle processor core's MEM stage.
- Converts the core's level MemRead/MemWrite strobes into a req/ack transaction on a variable-latency data-memory bus.
- Stalls the core until the transaction completes and returns registered read data on dReadData.
- Detects misaligned, out-of-range and conflicting accesses and reports them as errors instead of issuing them to the bus.

Parameters:
- DMEM_BASE, 32'h10010000, first legal byte address of data memory.
- DMEM_SIZE, 32'h00001000, size of the legal window in bytes; legal range is [DMEM_BASE, DMEM_BASE+DMEM_SIZE).
- TIMEOUT_CYCLES, 64, maximum number of REQ cycles without bus_ack before abort (used only with DMEM_TIMEOUT_EN); range 1..255.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- MemRead  in  1  core load strobe, held high for the whole MEM phase.
- MemWrite  in  1  core store strobe, held high for the whole MEM phase.
- dAddress  in  32  byte address from the ALU.
- dWriteData  in  32  store data.
- dReadData  out  32  registered load data returned to the core.
- stall  out  1  core must hold its state while this is 1.
- err  out  1  one-cycle pulse on an aborted access.
- err_sticky  out  1  set by any err; cleared only by rst.
- bus_req  out  1  bus request.
- bus_we  out  1  1 = write, 0 = read.
- bus_addr  out  32  word-aligned bus address.
- bus_wdata  out  32  bus write data.
- bus_ack  in  1  bus completion, single-cycle.
- bus_rdata  in  32  read data, valid while bus_ack = 1.

Behaviour:
- Clocking and reset: one clock. rst is synchronous and active-high and has priority over all other logic. On reset:
  - state = IDLE
  - dReadData = 0
  - bus_req = 0, bus_we = 0, bus_addr = 0, bus_wdata = 0
  - err = 0, err_sticky = 0
  - timeout counter = 0
- Reset mid-transaction drops bus_req in the next cycle, without waiting for bus_ack. A late bus_ack seen in IDLE is ignored.
- States: IDLE, REQ, DONE, ERR.
- IDLE:
  - MemRead and MemWrite both 0: stay in IDLE.
  - Exactly one strobe high, address legal: latch address, wdata and we into the bus registers. Next state REQ.
  - MemRead and MemWrite both 1, or dAddress[1:0] != 0, or address out of range: next state ERR. No bus_req is issued.
- REQ:
  - bus_req = 1. bus_addr, bus_we and bus_wdata stay stable until bus_ack.
  - bus_ack = 1: if a read, capture bus_rdata into dReadData. Next state DONE.
  - The minimum bus latency is bus_ack in the first REQ cycle.
- DONE: lasts one cycle with stall = 0 so the core advances. Any strobes still high are ignored. Next state IDLE.
- ERR: lasts one cycle. err = 1, err_sticky is set, stall = 0, dReadData is unchanged. Next state IDLE.
- stall is combinational:
  - 1 in REQ.
  - 1 in IDLE when a legal strobe is present.
  - 0 otherwise.
- A legal load therefore stalls the core for (1 + bus latency) cycles. dReadData is valid from the DONE cycle onward and holds until the next completed read.
- A store never modifies dReadData.
- Range check uses 33-bit unsigned arithmetic so DMEM_BASE+DMEM_SIZE cannot wrap. The last legal word is DMEM_BASE+DMEM_SIZE-4.

Optional Feature:
- Macro: DMEM_TIMEOUT_EN.
- Defined:
  - An 8-bit counter clears on entry to REQ and increments each REQ cycle without bus_ack.
  - When it reaches TIMEOUT_CYCLES, bus_req drops and the FSM goes to ERR (err pulse, err_sticky set, dReadData unchanged).
  - bus_ack arriving in the same cycle as the limit wins: the transaction completes normally.
- Not defined: no counter exists, and REQ waits for bus_ack indefinitely.

Test Plan:
- Load with zero wait: MemRead=1, dAddress=32'h10010004, bus_ack in the first REQ cycle with bus_rdata=32'hDEADBEEF -> bus_req high for 1 cycle; stall high for 2 cycles; dReadData=32'hDEADBEEF in DONE; err=0.
- Store with 3-cycle latency: MemWrite=1, dAddress=32'h10010FFC, dWriteData=32'h0000A5A5 -> bus_we=1, bus_addr=32'h10010FFC, bus_wdata=32'h0000A5A5 held stable for 3 cycles; stall high for 4 cycles; dReadData unchanged.
- Illegal accesses: dAddress=32'h10010002, then 32'h10011000, then MemRead=MemWrite=1 -> each case gives no bus_req, a one-cycle err pulse and err_sticky=1.
- Reset mid-transaction: rst during REQ, then bus_ack two cycles later -> bus_req=0 the cycle after rst; all outputs at reset values; the late ack is ignored.
- Held strobe after completion: MemRead kept high through DONE and for one IDLE cycle -> exactly one bus transaction in DONE, then a new transaction only because the strobe is still high in IDLE.
- Timeout (DMEM_TIMEOUT_EN defined, TIMEOUT_CYCLES=4): no bus_ack -> bus_req drops after 4 REQ cycles; err pulses; stall=0 in the ERR cycle.
